// File: rtl/bsg_skid_buffer_bypass.sv
// Two-entry skid buffer with a zero-latency bypass when empty.
// Optional saturating stall counter: define BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN.
module bsg_skid_buffer_bypass #(
  parameter int width_p           = 16,
  parameter int stall_cnt_width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_and_i
`ifdef BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN
  ,output logic [stall_cnt_width_p-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e             state_reg;
  logic [width_p-1:0] head_reg;
  logic [width_p-1:0] tail_reg;
  logic               enq;
  logic               deq;

  // Ready depends only on occupancy and reset, never on the downstream side.
  assign ready_and_o = (state_reg != FULL) & ~reset_i;
  assign v_o         = ~reset_i & ((state_reg != EMPTY) | v_i);
  assign data_o      = (state_reg == EMPTY) ? data_i : head_reg;
  assign enq         = v_i & ready_and_o;
  assign deq         = v_o & ready_and_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (enq & ~deq) state_reg <= ONE;
        ONE: begin
          if (deq & ~enq)      state_reg <= EMPTY;
          else if (enq & ~deq) state_reg <= FULL;
        end
        FULL:    if (deq) state_reg <= ONE;
        default: state_reg <= EMPTY;
      endcase
    end
  end

  // Payload storage is left unreset; enq/deq are already suppressed during reset.
  always_ff @(posedge clk_i) begin
    case (state_reg)
      EMPTY: if (enq & ~deq) head_reg <= data_i;
      ONE: begin
        if (enq & deq) head_reg <= data_i;
        else if (enq)  tail_reg <= data_i;
      end
      FULL:    if (deq) head_reg <= tail_reg;
      default: ;
    endcase
  end

`ifdef BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN
  logic [stall_cnt_width_p-1:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_reg <= '0;
    end else if (v_o & ~ready_and_i & ~(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_bsg_skid_buffer_bypass.sv
// Bench for bsg_skid_buffer_bypass: directed vector table, queue scoreboard on
// every cycle, randomized traffic with occasional resets, stall counter check.
module tb_bsg_skid_buffer_bypass;

  localparam int W  = 16;
  localparam int SW = 4;

  logic         clk;
  logic         reset;
  logic         v_in;
  logic [W-1:0] data_in;
  logic         ready_up;
  logic         v_out;
  logic [W-1:0] data_out;
  logic         ready_dn;
`ifdef BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN
  logic [SW-1:0] stall_cnt;
`endif

  int checks = 0;
  int passed = 0;

  bsg_skid_buffer_bypass #(.width_p(W), .stall_cnt_width_p(SW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .v_i         (v_in),
    .data_i      (data_in),
    .ready_and_o (ready_up),
    .v_o         (v_out),
    .data_o      (data_out),
    .ready_and_i (ready_dn)
`ifdef BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN
    ,.stall_cnt_o(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endfunction

  // Scoreboard: words accepted but not yet dequeued, oldest first.
  logic [W-1:0] sb_q[$];
  int           stall_exp = 0;

  always @(negedge clk) begin
    logic         exp_rdy, exp_v, enq, deq;
    logic [W-1:0] exp_d;
    exp_rdy = !reset && (sb_q.size() < 2);
    exp_v   = !reset && (sb_q.size() > 0 || v_in);
    exp_d   = (sb_q.size() > 0) ? sb_q[0] : data_in;
    chk("sb_ready", {31'b0, ready_up}, {31'b0, exp_rdy});
    chk("sb_valid", {31'b0, v_out}, {31'b0, exp_v});
    if (exp_v) chk("sb_data", {16'b0, data_out}, {16'b0, exp_d});
`ifdef BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN
    chk("sb_stall", {28'b0, stall_cnt}, stall_exp);
`endif
    enq = v_in && exp_rdy;
    deq = exp_v && ready_dn;
    if (reset) begin
      sb_q.delete();
      stall_exp = 0;
    end else begin
      if (enq) sb_q.push_back(data_in);
      if (deq) begin
        $display("deq data=%h t=%0t", sb_q[0], $time);
        void'(sb_q.pop_front());
      end
      if (exp_v && !ready_dn && stall_exp < (1 << SW) - 1) stall_exp++;
    end
  end

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         ev;
    logic [W-1:0] ed;
    logic         erdy;
  } vec_t;

  vec_t vecs[20];

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic rdy);
    reset    = r;
    v_in     = v;
    data_in  = d;
    ready_dn = rdy;
  endtask

  initial begin
    // rst, v, data, rdy  ->  v_o, data_o, ready_and_o
    vecs[0]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 16'hA001, 1'b0, 1'b1, 16'hA001, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'hA002, 1'b0, 1'b1, 16'hA001, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'hA003, 1'b0, 1'b1, 16'hA001, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'hA003, 1'b0, 1'b1, 16'hA001, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 16'hA001, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'h0BEE, 1'b1, 1'b1, 16'h0BEE, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'h0005, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 16'h0006, 1'b1, 1'b1, 16'h0005, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 16'h0007, 1'b0, 1'b1, 16'h0006, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 16'h00C1, 1'b0, 1'b1, 16'h00C1, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00C1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};

    drive(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].rdy);
      @(negedge clk);
      $display("vec %0d: v_o=%b data_o=%h ready=%b", i, v_out, data_out, ready_up);
      chk($sformatf("vec%0d_valid", i), {31'b0, v_out}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'b0, ready_up}, {31'b0, vecs[i].erdy});
      if (vecs[i].ev)
        chk($sformatf("vec%0d_data", i), {16'b0, data_out}, {16'b0, vecs[i].ed});
      @(posedge clk); #1;
    end

    // Random traffic; the scoreboard checks order, loss and duplication.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
            W'($urandom), $urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end

    // Drain must finish within a few cycles.
    begin
      bit drained = 0;
      drive(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 5 && !drained; i++) begin
        @(negedge clk);
        if (!v_out) drained = 1;
        @(posedge clk); #1;
      end
      chk("drain_done", {31'b0, drained}, 32'd1);
    end

`ifdef BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN
    drive(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h5555, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_sat", {28'b0, stall_cnt}, 32'hF);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bsg_skid_buffer_bypass.md
BSG_SKID_BUFFER_BYPASS -- requirements
Module: bsg_skid_buffer_bypass

Interface
REQ-001 Parameter: width_p, default 16, payload width in bits.
REQ-002 Parameter: stall_cnt_width_p, default 16, stall counter width; used only when the Configuration macro is defined.
REQ-003 clk_i  input  1  single clock; all state updates on posedge clk_i.
REQ-004 reset_i  input  1  reset; synchronous and active-high.
REQ-005 v_i  input  1  upstream valid.
REQ-006 data_i  input  width_p  upstream payload.
REQ-007 ready_and_o  output  1  upstream handshake; a transfer occurs when v_i and ready_and_o are both high.
REQ-008 v_o  output  1  downstream valid.
REQ-009 data_o  output  width_p  downstream payload.
REQ-010 ready_and_i  input  1  downstream ready; a dequeue occurs when v_o and ready_and_i are both high.
REQ-011 stall_cnt_o  output  stall_cnt_width_p  saturating stall count; present only when the Configuration macro is defined.

Function
REQ-012 The block SHALL hold a two-entry in-order store (head, tail) with occupancy state EMPTY, ONE or FULL.
REQ-013 ready_and_o SHALL equal (state != FULL) and ~reset_i; it SHALL NOT depend combinationally on ready_and_i, v_i or data_i.
REQ-014 In EMPTY: v_o = v_i and data_o = data_i (zero-latency bypass).
REQ-015 In EMPTY with v_i=1 and ready_and_i=1, the word SHALL pass through the same cycle and the state SHALL stay EMPTY.
REQ-016 In EMPTY with v_i=1 and ready_and_i=0, head SHALL capture data_i and the next state SHALL be ONE.
REQ-017 In ONE or FULL: v_o = 1 and data_o = head.
REQ-018 ONE with enqueue and dequeue: head <= data_i, next state ONE.
REQ-019 ONE with dequeue only: next state EMPTY.
REQ-020 ONE with enqueue only: tail <= data_i, next state FULL.
REQ-021 FULL with dequeue: head <= tail, next state ONE; v_i and data_i SHALL be ignored in FULL.
REQ-022 FULL without dequeue: hold all state.
REQ-023 Words SHALL leave in arrival order, with no loss and no duplication.
REQ-024 Latency: 0 cycles when EMPTY and ready_and_i=1; otherwise 1 cycle per word ahead of it in the store, plus downstream stall cycles.

Reset
REQ-025 While reset_i=1: ready_and_o=0, v_o=0, and the state SHALL be EMPTY at the next edge.
REQ-026 head and tail SHALL NOT be reset; data_o is don't-care whenever v_o=0.
REQ-027 Reset asserted while ONE or FULL SHALL discard the stored words; after reset deasserts, v_o SHALL equal v_i.
REQ-028 stall_cnt_o (when present) SHALL reset to 0.

Configuration
REQ-029 Macro: BSG_SKID_BUFFER_BYPASS_STALL_CNT_EN.
REQ-030 With the macro defined: stall_cnt_o SHALL increment each cycle that v_o=1 and ready_and_i=0, and SHALL saturate at all-ones.
REQ-031 Without the macro: no stall_cnt_o port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Pass-through: EMPTY, ready_and_i=1, v_i=1, data_i=0x1234 -> data_o=0x1234 and v_o=1 in the same cycle; state stays EMPTY.
REQ-033 Backpressure fill: ready_and_i=0, send 0xA001 then 0xA002 -> ready_and_o=0 from the next cycle; v_i=1 with 0xA003 is ignored.
REQ-034 Drain: from REQ-033, raise ready_and_i=1 -> data_o is 0xA001 then 0xA002 on consecutive cycles, then v_o=v_i; 0xA003 never appears.
REQ-035 Simultaneous in ONE: head=0x0005, v_i=1 with 0x0006, ready_and_i=1 -> 0x0005 dequeued and data_o=0x0006 next cycle; stays ONE.
REQ-036 Reset in FULL: assert reset_i for 1 cycle -> v_o=0 and ready_and_o=0 during reset; afterwards state EMPTY and stall_cnt_o=0.
REQ-037 Stall count (macro defined, stall_cnt_width_p=4): hold v_o=1 with ready_and_i=0 for 20 cycles -> stall_cnt_o=0xF.
